// File: rtl/sme_rng_pool.sv
// Randomness pool for the SME masked datapath: warms up sme_rng, then buffers
// guard-share word sets in a small FIFO that hands each set out exactly once.
module sme_rng_pool #(
  parameter  int XLEN   = 32,
  parameter  int SMAX   = 3,
  parameter  int DEPTH  = 4,
  parameter  int WARMUP = 16,
  localparam int RMAX   = SMAX + SMAX * (SMAX - 1) / 2,
  localparam int DW     = RMAX * XLEN,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  output logic          g_clk_req,
  output logic          rng_update,
  input  logic [DW-1:0] rng_in,
  input  logic          flush,
  output logic          mask_valid,
  input  logic          mask_ready,
  output logic [DW-1:0] mask_data,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WARMUP + 1);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   warm_cnt;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [DW-1:0]   mem [DEPTH];
  logic            full;
  logic            push;
  logic            pop;
  logic            do_flush;

  assign full      = (level == LW'(DEPTH));
  assign mask_data = mem[rd_ptr];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= WARM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WARM:    if (warm_cnt == CW'(WARMUP - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = WARM;
    endcase
  end

  // Flush wins over the handshake: a ready seen during a flush cycle is not a pop.
  always_comb begin
    mask_valid = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    do_flush   = 1'b0;
    rng_update = 1'b1;
    g_clk_req  = 1'b1;
    case (state)
      WARM: begin
        rng_update = 1'b1;
        g_clk_req  = 1'b1;
      end
      RUN: begin
        mask_valid = (level != '0);
        do_flush   = flush;
        pop        = mask_valid & mask_ready & ~flush;
        push       = (~full | pop) & ~flush;
        rng_update = push;
        g_clk_req  = ~full | flush;
      end
      default: begin
        rng_update = 1'b1;
        g_clk_req  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      warm_cnt <= '0;
    end else if (state == WARM) begin
      warm_cnt <= warm_cnt + CW'(1);
    end else begin
      warm_cnt <= '0;
    end
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (do_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Storage is cleared on reset so old masks can never reach mask_data.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= rng_in;
    end
  end

endmodule

// File: tb/tb_sme_rng_pool.sv
// Directed bench for sme_rng_pool: warm-up, full-rate pops, flush, stalls and async reset.
module tb_sme_rng_pool;

  localparam int XLEN   = 32;
  localparam int SMAX   = 3;
  localparam int RMAX   = 6;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 16;
  localparam int DW     = RMAX * XLEN;
  localparam int LW     = 3;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          g_clk_req;
  logic          rng_update;
  logic [DW-1:0] rng_in;
  logic          flush;
  logic          mask_valid;
  logic          mask_ready;
  logic [DW-1:0] mask_data;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sme_rng_pool #(
    .XLEN(XLEN), .SMAX(SMAX), .DEPTH(DEPTH), .WARMUP(WARMUP)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
    .rng_update(rng_update), .rng_in(rng_in), .flush(flush),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask_data(mask_data), .level(level)
  );

  always #5 g_clk = ~g_clk;

  // Word set offered by the RNG during cycle s; tagged so captures are traceable.
  function automatic logic [DW-1:0] pat(input int s);
    logic [DW-1:0] p;
    for (int i = 0; i < RMAX; i++)
      p[i*XLEN +: XLEN] = 32'hA500_0000 | (32'(s) << 8) | 32'(i);
    return p;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_lvl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle and hold the given inputs for all of it.
  task automatic apply_stimulus(input logic ready, input logic fl);
    @(posedge g_clk);
    #1;
    cyc++;
    rng_in     = pat(cyc);
    mask_ready = ready;
    flush      = fl;
    #1;
  endtask

  task automatic release_reset();
    @(posedge g_clk);
    #1;
    g_resetn   = 1'b1;
    cyc        = 0;
    rng_in     = pat(0);
    mask_ready = 1'b0;
    flush      = 1'b0;
    #1;
  endtask

  int exp_pop [6] = '{16, 17, 18, 19, 21, 22};

  initial begin
    g_resetn   = 1'b0;
    mask_ready = 1'b0;
    flush      = 1'b0;
    rng_in     = '0;
    repeat (3) @(posedge g_clk);
    #1;
    check_bit("rst_valid", mask_valid, 1'b0);
    check_bit("rst_update", rng_update, 1'b1);
    check_bit("rst_clkreq", g_clk_req, 1'b1);
    check_data("rst_data", mask_data, '0);
    check_lvl("rst_level", level, 3'd0);

    release_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) apply_stimulus(1'b0, 1'b0);
      check_bit("warm_valid", mask_valid, 1'b0);
      check_bit("warm_update", rng_update, 1'b1);
      check_bit("warm_clkreq", g_clk_req, 1'b1);
    end
    check_lvl("run_start_level", level, 3'd0);

    for (int c = 17; c <= 20; c++) begin
      apply_stimulus(1'b0, 1'b0);
      check_bit("fill_valid", mask_valid, 1'b1);
      check_lvl("fill_level", level, LW'(c - 16));
      check_data("fill_head", mask_data, pat(16));
      check_bit("fill_update", rng_update, c < 20);
      check_bit("fill_clkreq", g_clk_req, c < 20);
    end

    // Full with ready held: one pop and one capture per cycle, in capture order.
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, 1'b0);
      check_data("stream_head", mask_data, pat(exp_pop[k]));
      check_lvl("stream_level", level, 3'd4);
      check_bit("stream_update", rng_update, 1'b1);
      check_bit("stream_valid", mask_valid, 1'b1);
    end
    apply_stimulus(1'b0, 1'b0);
    check_data("idle_head", mask_data, pat(23));
    check_lvl("idle_level", level, 3'd4);
    check_bit("idle_update", rng_update, 1'b0);
    check_bit("idle_clkreq", g_clk_req, 1'b0);

    apply_stimulus(1'b1, 1'b1);
    check_bit("flush_update", rng_update, 1'b0);
    check_bit("flush_clkreq", g_clk_req, 1'b1);
    check_lvl("flush_level", level, 3'd4);
    apply_stimulus(1'b0, 1'b0);
    check_lvl("post_flush_level", level, 3'd0);
    check_bit("post_flush_valid", mask_valid, 1'b0);
    check_bit("post_flush_update", rng_update, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_lvl("refill_level", level, 3'd1);
    check_bit("refill_valid", mask_valid, 1'b1);
    check_data("refill_head", mask_data, pat(29));
    apply_stimulus(1'b1, 1'b1);
    check_lvl("flush2_level", level, 3'd2);
    check_bit("flush2_update", rng_update, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_lvl("flush2_after_level", level, 3'd0);
    check_bit("flush2_after_valid", mask_valid, 1'b0);

    apply_stimulus(1'b1, 1'b0);
    check_lvl("tog1_level", level, 3'd1);
    check_data("tog1_head", mask_data, pat(32));
    apply_stimulus(1'b0, 1'b0);
    check_lvl("tog0_level", level, 3'd1);
    check_data("tog0_head", mask_data, pat(33));
    apply_stimulus(1'b1, 1'b0);
    check_lvl("tog1b_level", level, 3'd2);
    check_data("tog1b_head_stable", mask_data, pat(33));
    apply_stimulus(1'b0, 1'b0);
    check_lvl("tog_after_level", level, 3'd2);
    check_data("tog_after_head", mask_data, pat(34));
    apply_stimulus(1'b0, 1'b0);
    check_lvl("pre_reset_level", level, 3'd3);
    check_data("pre_reset_head", mask_data, pat(34));

    // Reset dropped mid-cycle must take effect without waiting for an edge.
    #2;
    g_resetn = 1'b0;
    #1;
    check_bit("async_valid", mask_valid, 1'b0);
    check_lvl("async_level", level, 3'd0);
    check_bit("async_update", rng_update, 1'b1);
    check_bit("async_clkreq", g_clk_req, 1'b1);
    check_data("async_data", mask_data, '0);
    repeat (2) @(posedge g_clk);

    release_reset();
    for (int c = 1; c <= 16; c++) begin
      apply_stimulus(1'b0, c == 5);
      check_bit("rewarm_valid", mask_valid, 1'b0);
      if (c == 5) check_bit("rewarm_flush_clkreq", g_clk_req, 1'b1);
    end
    check_lvl("rewarm_level", level, 3'd0);
    apply_stimulus(1'b0, 1'b0);
    check_bit("rewarm_first_valid", mask_valid, 1'b1);
    check_lvl("rewarm_first_level", level, 3'd1);
    check_data("rewarm_first_head", mask_data, pat(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
